// File: rtl/display_scheduler_if.sv
// display_scheduler_if: content inputs, message handshake and scan drive of the display scheduler
interface display_scheduler_if;
    logic [19:0] base_bin;
    logic [19:0] msg_bin;
    logic        msg_req;
    logic [3:0]  blank_mask;
    logic        msg_ack;
    logic [3:0]  AN;
    logic [4:0]  digit_code;
    logic [1:0]  digit_sel;
    logic        showing_msg;
    modport master (
        output base_bin, msg_bin, msg_req, blank_mask,
        input  msg_ack, AN, digit_code, digit_sel, showing_msg
    );
    modport slave (
        input  base_bin, msg_bin, msg_req, blank_mask,
        output msg_ack, AN, digit_code, digit_sel, showing_msg
    );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: 4-digit scan controller arbitrating background value against timed messages
module display_scheduler #(
    parameter int SCAN_DIV    = 40000,
    parameter int HOLD_FRAMES = 500
) (
    input logic clk,
    input logic rst,
    display_scheduler_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    typedef enum logic [1:0] {BASE, PEND, MSG} state_t;
    state_t state, state_nx;
    logic [PW-1:0] pre;
    logic [1:0] idx;
    logic [FW-1:0] frame_cnt, frame_nx;
    logic [19:0] msg_reg, src;
    logic tick, boundary, accept, last_frame;
    assign tick = pre == PW'(SCAN_DIV - 1);
    assign boundary = tick && idx == 2'd3;
    assign accept = bus.msg_req && !bus.msg_ack;
    assign last_frame = frame_cnt == FW'(HOLD_FRAMES - 1);
    assign src = state == MSG ? msg_reg : bus.base_bin;
    // a new accept in MSG restarts the hold and outranks an expiring boundary
    always_comb begin
        state_nx = state;
        frame_nx = frame_cnt;
        case (state)
            BASE: state_nx = accept ? PEND : BASE;
            PEND: begin
                state_nx = boundary ? MSG : PEND;
                frame_nx = '0;
            end
            MSG: begin
                state_nx = (!accept && boundary && last_frame) ? BASE : MSG;
                frame_nx = accept ? '0 : !boundary ? frame_cnt : last_frame ? '0 : frame_cnt + 1'b1;
            end
            default: state_nx = BASE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre             <= '0;
            idx             <= '0;
            frame_cnt       <= '0;
            state           <= BASE;
            msg_reg         <= '0;
            bus.msg_ack     <= 1'b0;
            bus.AN          <= 4'hf;
            bus.digit_code  <= '0;
            bus.digit_sel   <= '0;
            bus.showing_msg <= 1'b0;
        end else begin
            pre             <= tick ? '0 : pre + 1'b1;
            state           <= state_nx;
            frame_cnt       <= frame_nx;
            bus.msg_ack     <= accept;
            bus.showing_msg <= state_nx == MSG;
            if (accept) msg_reg <= bus.msg_bin;
            if (tick) begin
                idx            <= idx + 1'b1;
                bus.AN         <= ~(4'b0001 << idx) | bus.blank_mask;
                bus.digit_sel  <= idx;
                bus.digit_code <= bus.blank_mask[idx] ? 5'd0 : src[idx*5 +: 5];
            end
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: scoreboard bench; stimulus queues per-tick expectations, a monitor checks each tick
module tb_display_scheduler;
    localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AB = 4'b1111;
    localparam logic [19:0] BASEV = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [19:0] M1 = {5'd7, 5'd6, 5'd5, 5'd4};
    localparam logic [19:0] M9 = {5'd9, 5'd9, 5'd9, 5'd9};
    localparam logic [19:0] MC = {5'd13, 5'd12, 5'd11, 5'd10};
    typedef struct {
        int         t;
        logic [3:0] an;
        logic [4:0] code;
        logic [1:0] sel;
        logic       show;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int mon_t;
    exp_t q[$];
    exp_t e;
    display_scheduler_if bus();
    display_scheduler #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic ex(input int t, input logic [3:0] an, input logic [4:0] code, input logic show);
        exp_t x;
        x.t = t;
        x.an = an;
        x.code = code;
        x.sel = 2'((t - 1) % 4);
        x.show = show;
        q.push_back(x);
    endtask
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic req(input int c, input logic [19:0] v);
        wait_cyc(c);
        bus.msg_bin = v;
        bus.msg_req = 1'b1;
        @(negedge clk);
        chk("ack_high", bus.msg_ack, 1);
        bus.msg_req = 1'b0;
        @(negedge clk);
        chk("ack_low", bus.msg_ack, 0);
    endtask
    initial forever begin
        @(negedge clk);
        if (rst && cyc != 0 && cyc % 4 == 0) begin
            mon_t = cyc / 4;
            while (q.size() != 0 && q[0].t < mon_t) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tick%0d: expectation never observed (now tick %0d)", q[0].t, mon_t);
                void'(q.pop_front());
            end
            if (q.size() != 0 && q[0].t == mon_t) begin
                e = q.pop_front();
                n_cmp++;
                if ({bus.AN, bus.digit_code, bus.digit_sel, bus.showing_msg} !== {e.an, e.code, e.sel, e.show}) begin
                    n_bad++;
                    $display("FAIL tick%0d: got AN=%b code=%0d sel=%0d show=%b expected AN=%b code=%0d sel=%0d show=%b",
                             mon_t, bus.AN, bus.digit_code, bus.digit_sel, bus.showing_msg, e.an, e.code, e.sel, e.show);
                end
            end
        end
    end
    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish (cyc %0d)", cyc);
        $fatal(1);
    end
    initial begin
        bus.base_bin = BASEV;
        bus.msg_bin = '0;
        bus.msg_req = 1'b0;
        bus.blank_mask = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_an", bus.AN, AB);
        chk("rst_code", bus.digit_code, 0);
        chk("rst_sel", bus.digit_sel, 0);
        chk("rst_ack", bus.msg_ack, 0);
        chk("rst_show", bus.showing_msg, 0);
        rst = 1'b1;
        ex(1, A0, 0, 0); ex(2, A1, 1, 0); ex(3, A2, 2, 0); ex(4, A3, 3, 0); ex(5, A0, 0, 0);
        wait_cyc(3);
        chk("pre_tick_an", bus.AN, AB);
        // message accepted mid-frame, shown from the next frame for two frames
        wait_cyc(21);
        ex(6, A1, 1, 0); ex(7, A2, 2, 0); ex(8, A3, 3, 1);
        ex(9, A0, 4, 1); ex(10, A1, 5, 1); ex(11, A2, 6, 1); ex(12, A3, 7, 1);
        ex(13, A0, 4, 1); ex(14, A1, 5, 1); ex(15, A2, 6, 1); ex(16, A3, 7, 0);
        ex(17, A0, 0, 0);
        req(21, M1);
        chk("pend_show", bus.showing_msg, 0);
        wait_cyc(31);
        chk("pend_show_late", bus.showing_msg, 0);
        wait_cyc(33);
        chk("msg_show", bus.showing_msg, 1);
        // blanking digits 0 and 2 across base and message display
        wait_cyc(69);
        bus.blank_mask = 4'b0101;
        ex(18, A1, 1, 0); ex(19, AB, 0, 0); ex(20, A3, 3, 0); ex(21, AB, 0, 0);
        ex(22, A1, 1, 0); ex(23, AB, 0, 0); ex(24, A3, 3, 1);
        ex(25, AB, 0, 1); ex(26, A1, 5, 1); ex(27, AB, 0, 1); ex(28, A3, 7, 1);
        ex(29, AB, 0, 1); ex(30, A1, 5, 1); ex(31, AB, 0, 1); ex(32, A3, 7, 0);
        ex(33, AB, 0, 0); ex(34, A1, 1, 0);
        req(85, M1);
        wait_cyc(133);
        bus.blank_mask = 4'b0000;
        // restart at the third message tick
        wait_cyc(137);
        ex(35, A2, 2, 0); ex(36, A3, 3, 1);
        ex(37, A0, 4, 1); ex(38, A1, 5, 1); ex(39, A2, 6, 1); ex(40, A3, 9, 1);
        ex(41, A0, 9, 1); ex(42, A1, 9, 1); ex(43, A2, 9, 1); ex(44, A3, 9, 0);
        ex(45, A0, 0, 0);
        req(137, M1);
        req(156, M9);
        // accept landing on the hold-expiry boundary
        wait_cyc(181);
        ex(46, A1, 1, 0); ex(47, A2, 2, 0); ex(48, A3, 3, 1);
        ex(49, A0, 4, 1); ex(50, A1, 5, 1); ex(51, A2, 6, 1); ex(52, A3, 7, 1);
        ex(53, A0, 4, 1); ex(54, A1, 5, 1); ex(55, A2, 6, 1); ex(56, A3, 7, 1);
        ex(57, A0, 10, 1); ex(58, A1, 11, 1); ex(59, A2, 12, 1); ex(60, A3, 13, 1);
        ex(61, A0, 10, 1); ex(62, A1, 11, 1); ex(63, A2, 12, 1); ex(64, A3, 13, 0);
        ex(65, A0, 0, 0);
        req(181, M1);
        req(223, MC);
        chk("collide_show", bus.showing_msg, 1);
        // reset while a message is displayed and a request is pending
        wait_cyc(261);
        ex(66, A1, 1, 0); ex(67, A2, 2, 0); ex(68, A3, 3, 1); ex(69, A0, 4, 1); ex(70, A1, 5, 1);
        req(261, M1);
        wait_cyc(282);
        bus.msg_bin = M9;
        bus.msg_req = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("midrst_an", bus.AN, AB);
        chk("midrst_show", bus.showing_msg, 0);
        chk("midrst_ack", bus.msg_ack, 0);
        chk("midrst_code", bus.digit_code, 0);
        bus.msg_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_ack_held", bus.msg_ack, 0);
        rst = 1'b1;
        ex(1, A0, 0, 0); ex(2, A1, 1, 0); ex(3, A2, 2, 0); ex(4, A3, 3, 0); ex(5, A0, 0, 0);
        wait_cyc(2);
        chk("post_rst_ack", bus.msg_ack, 0);
        chk("post_rst_show", bus.showing_msg, 0);
        wait_cyc(22);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Scan controller and arbiter for the 4-digit seven-segment display.
- Generates the digit refresh tick and one-hot, active-low anode drive.
- Arbitrates digit content between a background value and a timed message from a requester.
- Outputs the 5-bit digit code for the existing binary-to-segment decoder, which drives the cathodes.

Parameters:
- SCAN_DIV, 40000: clk cycles per digit slot. Minimum 2.
- HOLD_FRAMES, 500: number of full 4-digit frames a message is shown. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- base_bin  in  20  background value; digit k = bits [5k+4:5k].
- msg_bin  in  20  message value, same packing; sampled on accept.
- msg_req  in  1  message request; held high until msg_ack is seen, then dropped.
- blank_mask  in  4  bit k=1 blanks digit k; sampled at tick.
- msg_ack  out  1  one-cycle accept pulse.
- AN  out  4  anode enables, active-low.
- digit_code  out  5  code for the currently enabled digit.
- digit_sel  out  2  index of the currently enabled digit.
- showing_msg  out  1  high while the MSG state owns the display.

Behaviour:
- Reset (rst=0, async), all registers cleared:
  - AN=4'b1111, digit_code=0, digit_sel=0, msg_ack=0, showing_msg=0.
  - Prescaler=0, idx=0, frame_cnt=0, state=BASE, msg register=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for one cycle when the count equals SCAN_DIV-1.
- On tick:
  - AN <= ~(1<<idx) | blank_mask.
  - digit_sel <= idx.
  - digit_code <= slice idx of the selected source; 0 if blanked.
  - idx <= idx+1, wrapping 3 to 0.
  - The first tick after reset drives digit 0.
- Frame boundary: a tick with idx==3 (digit 3 being loaded).
- Source selection:
  - msg register when state==MSG at the tick.
  - base_bin otherwise, including PEND.
- Accept rule:
  - Accept when msg_req=1 and msg_ack=0, in any state.
  - Capture msg_bin into the msg register.
  - msg_ack=1 in the following cycle.
  - A held msg_req therefore accepts at most every other cycle.
- State machine:
  - BASE: accept goes to PEND.
  - PEND: waits for the frame boundary, then goes to MSG with frame_cnt=0. A new accept overwrites the msg register and stays in PEND.
  - MSG: at each frame boundary, frame_cnt increments. At the boundary where frame_cnt==HOLD_FRAMES-1, go to BASE and set frame_cnt=0.
  - MSG with a new accept: overwrite the msg register, frame_cnt=0, stay in MSG. The new value appears from the next tick (mid-frame switch allowed).
- Simultaneous events:
  - Accept in the same cycle as the hold-expiry boundary: the accept wins. State stays MSG, frame_cnt=0.
  - Accept in PEND in the same cycle as the boundary: the new value is captured and state goes to MSG.
- Message duration: the message occupies exactly HOLD_FRAMES×4 ticks, each starting at digit 0, unless restarted.
- showing_msg is registered and equals (state==MSG).
- Blanking never alters state, idx or frame counting.
- Reset mid-message:
  - Immediately returns to BASE with AN=1111.
  - A pending message is lost and no ack is issued.

Test Plan:
- Bench uses SCAN_DIV=4, HOLD_FRAMES=2.
- Reset/scan: rst low then high, base_bin={5'd3,5'd2,5'd1,5'd0}.
  - Until the first tick: AN=1111.
  - Ticks every 4 clks give (AN,digit_code) = (1110,0), (1101,1), (1011,2), (0111,3), then (1110,0) again.
- Handshake/alignment: msg_req pulsed mid-frame with msg_bin={5'd7,5'd6,5'd5,5'd4}.
  - msg_ack high exactly 1 cycle; showing_msg stays 0 until the digit-3 tick.
  - The following tick shows (1110,4).
  - 8 ticks of message digits 4,5,6,7,4,5,6,7, then base digit 0 and showing_msg=0.
- Blanking: blank_mask=4'b0101 during base display.
  - Digits 0 and 2 give AN=1111 with digit_code=0.
  - Digits 1 and 3 unaffected.
  - The message still expires after 8 ticks.
- Restart: second msg_req (msg_bin=all 5'd9) at the third message tick.
  - Ack issued; code 9 appears from the next tick.
  - The message then lasts until 2 further frame boundaries.
- Collision: msg_req asserted so the accept lands on the hold-expiry boundary cycle.
  - State stays MSG, frame_cnt resets, new content shown for 2 more frames.
- Reset mid-message: rst low during MSG.
  - AN=1111, showing_msg=0, msg_ack=0 immediately without a clock edge.
  - After release, the scan restarts at digit 0 with base content.
